// File: rtl/veda_mem_arb.sv
// veda_mem_arb: two-port round-robin arbiter in front of a single veda_mem_2
// (64 x 8, synchronous). The granted command is registered onto the memory
// bus, tagged with the requester id, and the memory's dataOut is routed back
// to that requester as a one-cycle response pulse RD_LAT+1 edges later.
module veda_mem_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic              r0_mode,
  input  logic [ADDR_W-1:0] r0_addr_a,
  input  logic [ADDR_W-1:0] r0_addr_b,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_data,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic              r1_mode,
  input  logic [ADDR_W-1:0] r1_addr_a,
  input  logic [ADDR_W-1:0] r1_addr_b,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_data,

  output logic              mem_we,
  output logic              mem_Mode,
  output logic [ADDR_W-1:0] mem_address_a,
  output logic [ADDR_W-1:0] mem_address_b,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,

  output logic              busy
);

  // Stage 0 is loaded on the accept edge; the last stage lines up with the
  // cycle in which the memory's dataOut is valid for that command.
  localparam int DEPTH = 1 + RD_LAT;

  logic              w_g0;
  logic              w_g1;
  logic              w_any;
  logic              w_sel_we;
  logic              w_sel_mode;
  logic [ADDR_W-1:0] w_sel_addr_a;
  logic [ADDR_W-1:0] w_sel_addr_b;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              r_prio;
  logic              r_mem_we;
  logic              r_mem_mode;
  logic [ADDR_W-1:0] r_mem_addr_a;
  logic [ADDR_W-1:0] r_mem_addr_b;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DEPTH-1:0]  r_tag_v;
  logic [DEPTH-1:0]  r_tag_id;
  logic              r_r0_rsp_valid;
  logic [DATA_W-1:0] r_r0_rsp_data;
  logic              r_r1_rsp_valid;
  logic [DATA_W-1:0] r_r1_rsp_data;

  // Grants are suppressed while rst is high so nothing is accepted in reset.
  // r_prio == 0 means requester 0 wins a tie.
  assign w_g0 = !rst && r0_valid && (!r1_valid || !r_prio);
  assign w_g1 = !rst && r1_valid && !w_g0;
  assign w_any = w_g0 || w_g1;

  assign r0_ready = w_g0;
  assign r1_ready = w_g1;

  // Command fields of whichever requester holds the grant.
  assign w_sel_we     = w_g1 ? r1_we     : r0_we;
  assign w_sel_mode   = w_g1 ? r1_mode   : r0_mode;
  assign w_sel_addr_a = w_g1 ? r1_addr_a : r0_addr_a;
  assign w_sel_addr_b = w_g1 ? r1_addr_b : r0_addr_b;
  assign w_sel_wdata  = w_g1 ? r1_wdata  : r0_wdata;

  // Round-robin pointer: after a grant, the other requester wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_any) begin
      r_prio <= w_g0;
    end
  end

  // Memory command bus; idle cycles drop we and hold the other fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we     <= 1'b0;
      r_mem_mode   <= 1'b0;
      r_mem_addr_a <= '0;
      r_mem_addr_b <= '0;
      r_mem_wdata  <= '0;
    end else if (w_any) begin
      r_mem_we     <= w_sel_we;
      r_mem_mode   <= w_sel_mode;
      r_mem_addr_a <= w_sel_addr_a;
      r_mem_addr_b <= w_sel_addr_b;
      r_mem_wdata  <= w_sel_wdata;
    end else begin
      r_mem_we     <= 1'b0;
    end
  end

  // Tag stage 0 records whether a command issued this edge and for whom.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v[0]  <= 1'b0;
      r_tag_id[0] <= 1'b0;
    end else begin
      r_tag_v[0]  <= w_any;
      r_tag_id[0] <= w_g1;
    end
  end

  // Remaining tag stages shift unconditionally every edge.
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag_v[gi]  <= 1'b0;
          r_tag_id[gi] <= 1'b0;
        end else begin
          r_tag_v[gi]  <= r_tag_v[gi-1];
          r_tag_id[gi] <= r_tag_id[gi-1];
        end
      end
    end
  endgenerate

  // Route dataOut to the tagged requester; data holds between its pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r0_rsp_valid <= 1'b0;
      r_r0_rsp_data  <= '0;
      r_r1_rsp_valid <= 1'b0;
      r_r1_rsp_data  <= '0;
    end else begin
      r_r0_rsp_valid <= r_tag_v[DEPTH-1] && !r_tag_id[DEPTH-1];
      r_r1_rsp_valid <= r_tag_v[DEPTH-1] &&  r_tag_id[DEPTH-1];
      if (r_tag_v[DEPTH-1] && !r_tag_id[DEPTH-1]) begin
        r_r0_rsp_data <= mem_dataOut;
      end
      if (r_tag_v[DEPTH-1] && r_tag_id[DEPTH-1]) begin
        r_r1_rsp_data <= mem_dataOut;
      end
    end
  end

  assign mem_we        = r_mem_we;
  assign mem_Mode      = r_mem_mode;
  assign mem_address_a = r_mem_addr_a;
  assign mem_address_b = r_mem_addr_b;
  assign mem_dataIn    = r_mem_wdata;

  assign r0_rsp_valid = r_r0_rsp_valid;
  assign r0_rsp_data  = r_r0_rsp_data;
  assign r1_rsp_valid = r_r1_rsp_valid;
  assign r1_rsp_data  = r_r1_rsp_data;

  assign busy = |r_tag_v;

endmodule

// File: tb/tb_veda_mem_arb.sv
// Bench for veda_mem_arb: two instances (RD_LAT=1 and RD_LAT=3) share one
// stimulus stream, each with its own behavioural memory. Expected values come
// from a transaction-level model: a grant rule, a reference memory, and a
// queue of issued commands with their accept cycle.
module tb_veda_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       r0_valid, r0_we, r0_mode;
  logic [5:0] r0_addr_a, r0_addr_b;
  logic [7:0] r0_wdata;
  logic       r1_valid, r1_we, r1_mode;
  logic [5:0] r1_addr_a, r1_addr_b;
  logic [7:0] r1_wdata;

  logic       a_r0_ready, a_r1_ready, a_r0_rsp_valid, a_r1_rsp_valid;
  logic [7:0] a_r0_rsp_data, a_r1_rsp_data;
  logic       a_mem_we, a_mem_mode, a_busy;
  logic [5:0] a_mem_aa, a_mem_ab;
  logic [7:0] a_mem_din, a_mem_dout;

  logic       b_r0_ready, b_r1_ready, b_r0_rsp_valid, b_r1_rsp_valid;
  logic [7:0] b_r0_rsp_data, b_r1_rsp_data;
  logic       b_mem_we, b_mem_mode, b_busy;
  logic [5:0] b_mem_aa, b_mem_ab;
  logic [7:0] b_mem_din, b_mem_dout;

  veda_mem_arb #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(a_r0_ready), .r0_we(r0_we), .r0_mode(r0_mode),
    .r0_addr_a(r0_addr_a), .r0_addr_b(r0_addr_b), .r0_wdata(r0_wdata),
    .r0_rsp_valid(a_r0_rsp_valid), .r0_rsp_data(a_r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(a_r1_ready), .r1_we(r1_we), .r1_mode(r1_mode),
    .r1_addr_a(r1_addr_a), .r1_addr_b(r1_addr_b), .r1_wdata(r1_wdata),
    .r1_rsp_valid(a_r1_rsp_valid), .r1_rsp_data(a_r1_rsp_data),
    .mem_we(a_mem_we), .mem_Mode(a_mem_mode), .mem_address_a(a_mem_aa),
    .mem_address_b(a_mem_ab), .mem_dataIn(a_mem_din), .mem_dataOut(a_mem_dout),
    .busy(a_busy)
  );

  veda_mem_arb #(.ADDR_W(6), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(b_r0_ready), .r0_we(r0_we), .r0_mode(r0_mode),
    .r0_addr_a(r0_addr_a), .r0_addr_b(r0_addr_b), .r0_wdata(r0_wdata),
    .r0_rsp_valid(b_r0_rsp_valid), .r0_rsp_data(b_r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(b_r1_ready), .r1_we(r1_we), .r1_mode(r1_mode),
    .r1_addr_a(r1_addr_a), .r1_addr_b(r1_addr_b), .r1_wdata(r1_wdata),
    .r1_rsp_valid(b_r1_rsp_valid), .r1_rsp_data(b_r1_rsp_data),
    .mem_we(b_mem_we), .mem_Mode(b_mem_mode), .mem_address_a(b_mem_aa),
    .mem_address_b(b_mem_ab), .mem_dataIn(b_mem_din), .mem_dataOut(b_mem_dout),
    .busy(b_busy)
  );

  // Behavioural memories: write address_a, read address_b (read-before-write),
  // dataOut valid RD_LAT edges after the sampling edge.
  logic       mem_init;
  logic [7:0] ma [64];
  logic [7:0] pa;
  logic [7:0] mb [64];
  logic [7:0] pb [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ma[i] <= 8'(i * 3 + 1);
    end else begin
      pa <= ma[a_mem_ab];
      if (a_mem_we) ma[a_mem_aa] <= a_mem_din;
    end
  end
  assign a_mem_dout = pa;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mb[i] <= 8'(i * 3 + 1);
    end else begin
      pb[0] <= mb[b_mem_ab];
      pb[1] <= pb[0];
      pb[2] <= pb[1];
      if (b_mem_we) mb[b_mem_aa] <= b_mem_din;
    end
  end
  assign b_mem_dout = pb[2];

  // ---------------- reference model state ----------------
  typedef struct {
    int         acc;
    logic       id;
    logic [7:0] data;
  } pend_t;

  pend_t      pq[$];
  logic [7:0] rm [64];
  logic       m_prio;
  logic       e_we, e_mode;
  logic [5:0] e_aa, e_ab;
  logic [7:0] e_din;
  logic [7:0] exp_d0 [2];
  logic [7:0] exp_d1 [2];

  int cyc, total, bad;
  int acc0, acc1, p0_a, p1_a, p0_b, p1_b;
  int pulses, busy_b_cnt, last_rsp_b_cyc;
  logic last_g0, last_g1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check outputs, advance model, clock.
  task automatic tick();
    logic g0, g1, ev0, ev1, eb;
    int lat;
    string tg;
    #1;
    if (rst) begin
      g0 = 1'b0; g1 = 1'b0;
    end else if (r0_valid && r1_valid) begin
      g0 = (m_prio == 1'b0); g1 = !g0;
    end else begin
      g0 = r0_valid; g1 = r1_valid;
    end
    last_g0 = g0;
    last_g1 = g1;

    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      tg  = (i == 0) ? "L1" : "L3";
      ev0 = 1'b0; ev1 = 1'b0; eb = 1'b0;
      foreach (pq[j]) begin
        if (pq[j].acc + 2 + lat == cyc) begin
          if (pq[j].id) begin ev1 = 1'b1; exp_d1[i] = pq[j].data; end
          else          begin ev0 = 1'b1; exp_d0[i] = pq[j].data; end
        end
        if (cyc - pq[j].acc >= 1 && cyc - pq[j].acc <= lat + 1) eb = 1'b1;
      end
      chk({tg, "_r0_ready"}, (i == 0) ? a_r0_ready : b_r0_ready, g0);
      chk({tg, "_r1_ready"}, (i == 0) ? a_r1_ready : b_r1_ready, g1);
      chk({tg, "_mem_we"},   (i == 0) ? a_mem_we   : b_mem_we,   e_we);
      chk({tg, "_mem_mode"}, (i == 0) ? a_mem_mode : b_mem_mode, e_mode);
      chk({tg, "_mem_aa"},   (i == 0) ? a_mem_aa   : b_mem_aa,   e_aa);
      chk({tg, "_mem_ab"},   (i == 0) ? a_mem_ab   : b_mem_ab,   e_ab);
      chk({tg, "_mem_din"},  (i == 0) ? a_mem_din  : b_mem_din,  e_din);
      chk({tg, "_r0_rsp_valid"}, (i == 0) ? a_r0_rsp_valid : b_r0_rsp_valid, ev0);
      chk({tg, "_r1_rsp_valid"}, (i == 0) ? a_r1_rsp_valid : b_r1_rsp_valid, ev1);
      chk({tg, "_r0_rsp_data"},  (i == 0) ? a_r0_rsp_data  : b_r0_rsp_data,  exp_d0[i]);
      chk({tg, "_r1_rsp_data"},  (i == 0) ? a_r1_rsp_data  : b_r1_rsp_data,  exp_d1[i]);
      chk({tg, "_busy"},         (i == 0) ? a_busy : b_busy, eb);
    end

    // Observations for sequence-level checks.
    if (a_r0_rsp_valid === 1'b1) p0_a++;
    if (a_r1_rsp_valid === 1'b1) p1_a++;
    if (b_r0_rsp_valid === 1'b1) begin p0_b++; last_rsp_b_cyc = cyc; end
    if (b_r1_rsp_valid === 1'b1) p1_b++;
    pulses += int'(a_r0_rsp_valid === 1'b1) + int'(a_r1_rsp_valid === 1'b1)
            + int'(b_r0_rsp_valid === 1'b1) + int'(b_r1_rsp_valid === 1'b1);
    if (b_busy === 1'b1) busy_b_cnt++;

    // Model update for the coming edge.
    if (rst) begin
      pq.delete();
      m_prio = 1'b0;
      e_we = 1'b0; e_mode = 1'b0; e_aa = '0; e_ab = '0; e_din = '0;
      for (int i = 0; i < 2; i++) begin exp_d0[i] = '0; exp_d1[i] = '0; end
    end else if (g0 || g1) begin
      pend_t p;
      e_we   = g1 ? r1_we     : r0_we;
      e_mode = g1 ? r1_mode   : r0_mode;
      e_aa   = g1 ? r1_addr_a : r0_addr_a;
      e_ab   = g1 ? r1_addr_b : r0_addr_b;
      e_din  = g1 ? r1_wdata  : r0_wdata;
      p.acc  = cyc;
      p.id   = g1;
      p.data = rm[e_ab];
      pq.push_back(p);
      if (e_we) rm[e_aa] = e_din;
      m_prio = g0 ? 1'b1 : 1'b0;
      if (g0) acc0++; else acc1++;
    end else begin
      e_we = 1'b0;
    end
    while (pq.size() > 0 && pq[0].acc + 5 < cyc) void'(pq.pop_front());

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic rs,
                       input logic v0, input logic we0, input logic [5:0] a0,
                       input logic [5:0] b0, input logic [7:0] d0,
                       input logic v1, input logic we1, input logic [5:0] a1,
                       input logic [5:0] b1, input logic [7:0] d1);
    rst = rs;
    r0_valid = v0; r0_we = we0; r0_mode = 1'b0; r0_addr_a = a0; r0_addr_b = b0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_mode = 1'b1; r1_addr_a = a1; r1_addr_b = b1; r1_wdata = d1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0);
      tick();
    end
  endtask

  typedef struct {
    logic       rs;
    logic       v0, we0;
    logic [5:0] a0, b0;
    logic [7:0] d0;
    logic       v1, we1;
    logic [5:0] a1, b1;
    logic [7:0] d1;
    logic       er0, er1;
  } vec_t;

  function automatic vec_t mk(input logic rs,
      input logic v0, input logic we0, input logic [5:0] a0, input logic [5:0] b0, input logic [7:0] d0,
      input logic v1, input logic we1, input logic [5:0] a1, input logic [5:0] b1, input logic [7:0] d1,
      input logic er0, input logic er1);
    vec_t v;
    v.rs = rs; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int k_acc;
    cyc = 0; total = 0; bad = 0;
    acc0 = 0; acc1 = 0; p0_a = 0; p1_a = 0; p0_b = 0; p1_b = 0;
    pulses = 0; busy_b_cnt = 0; last_rsp_b_cyc = -1;
    m_prio = 1'b0; e_we = 1'b0; e_mode = 1'b0; e_aa = '0; e_ab = '0; e_din = '0;
    for (int i = 0; i < 2; i++) begin exp_d0[i] = '0; exp_d1[i] = '0; end
    for (int i = 0; i < 64; i++) rm[i] = 8'(i * 3 + 1);

    // Power-up: bring both DUTs and memories to a known state unchecked.
    mem_init = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0);
    repeat (3) @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);

    // Directed table: reset, single requester, contention, fairness.
    //            rs  v0 we0 a0 b0 d0       v1 we1 a1  b1  d1     r0 r1
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'd0,   1, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'd0,   1, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 5, 0, 8'd27,  0, 0, 0,  0,  8'd0,  1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5, 8'd0,   0, 0, 0,  0,  8'd0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   1, 0, 0,  9,  8'd0,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 1, 8, 8, 8'd26, 1, 1, 23, 23, 8'd25, (i % 2) == 0, (i % 2) == 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   1, 0, 0,  23, 8'd0,  0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8, 8'd0,   1, 0, 0,  23, 8'd0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0,  0,  8'd0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8, 8'd0,   0, 0, 0,  0,  8'd0,  1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8, 8'd0,   1, 0, 0,  23, 8'd0,  0, 1));

    foreach (tbl[i]) begin
      if (i == 2) begin
        acc0 = 0; acc1 = 0; p0_a = 0; p1_a = 0; p0_b = 0; p1_b = 0;
      end
      drive(tbl[i].rs, tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].b0, tbl[i].d0,
            tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].b1, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_r0_ready", i), a_r0_ready, tbl[i].er0);
      chk($sformatf("tbl%0d_r1_ready", i), a_r1_ready, tbl[i].er1);
      tick();
    end
    idle(8);
    chk("pulses_eq_accepts_r0_L1", p0_a, acc0);
    chk("pulses_eq_accepts_r1_L1", p1_a, acc1);
    chk("pulses_eq_accepts_r0_L3", p0_b, acc0);
    chk("pulses_eq_accepts_r1_L3", p1_b, acc1);

    // Reset mid-flight: two accepts, rst one edge later, no pulses afterwards.
    drive(1'b0, 1'b1, 1'b1, 6'd3, 6'd4, 8'hA5, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0, 1'b1, 1'b0, 6'd0, 6'd3, 8'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 8'd0, 1'b1, 1'b0, 6'd0, 6'd0, 8'd0);
    tick();
    pulses = 0;
    tick();
    idle(8);
    chk("rst_mid_no_pulses", pulses, 0);
    chk("rst_mid_busy_L1", a_busy, 1'b0);
    chk("rst_mid_busy_L3", b_busy, 1'b0);

    // RD_LAT=3 single read of address 20 after a write of 8'h77.
    drive(1'b0, 1'b1, 1'b1, 6'd20, 6'd0, 8'h77, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0);
    tick();
    idle(7);
    busy_b_cnt = 0;
    last_rsp_b_cyc = -1;
    k_acc = cyc;
    drive(1'b0, 1'b1, 1'b0, 6'd0, 6'd20, 8'd0, 1'b0, 1'b0, 6'd0, 6'd0, 8'd0);
    tick();
    idle(8);
    chk("lat3_rsp_cycle", last_rsp_b_cyc, k_acc + 5);
    chk("lat3_rsp_data", b_r0_rsp_data, 8'h77);
    chk("lat3_busy_cycles", busy_b_cnt, 4);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom_range(0, 15)),
            6'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom_range(0, 15)),
            6'($urandom_range(0, 15)), 8'($urandom));
      r0_mode = 1'($urandom);
      r1_mode = 1'($urandom);
      tick();
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/veda_mem_arb.md
Name: veda_mem_arb

Overview:
- Two-port round-robin arbiter that shares one veda_mem_2 instance (64 x 8, synchronous) between two requesters.
- Accepts one command per cycle through valid/ready handshakes and drives the memory command bus from registers.
- Tags each issued command and routes the memory's dataOut back to the issuing requester as a one-cycle response pulse.
- Sits between two client blocks (e.g. a DMA-style filler and a compute consumer) and the memory.

Parameters:
- ADDR_W, 6, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, clock edges from the memory's command-sampling edge until its dataOut is valid (legal range 1..4).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- r0_valid  input  1  requester 0 command valid.
- r0_ready  output  1  requester 0 command accepted this cycle (combinational).
- r0_we  input  1  write enable forwarded to memory.
- r0_mode  input  1  Mode bit forwarded to memory.
- r0_addr_a  input  ADDR_W  address_a forwarded.
- r0_addr_b  input  ADDR_W  address_b forwarded.
- r0_wdata  input  DATA_W  dataIn forwarded.
- r0_rsp_valid  output  1  one-cycle pulse: response for requester 0.
- r0_rsp_data  output  DATA_W  memory dataOut for that command.
- r1_*  same nine signals for requester 1.
- mem_we  output  1  to veda_mem_2 we.
- mem_Mode  output  1  to Mode.
- mem_address_a  output  ADDR_W  to address_a.
- mem_address_b  output  ADDR_W  to address_b.
- mem_dataIn  output  DATA_W  to dataIn.
- mem_dataOut  input  DATA_W  from dataOut.
- busy  output  1  high while any issued command's response is still pending.

Behaviour:
- Reset (rst high at an edge): mem_we=0, mem_Mode=0, mem_address_a/b=0, mem_dataIn=0. Both rsp_valid=0, rsp_data=0. busy=0. Priority pointer = requester 0. Tag pipeline cleared. Reset is held for as long as rst is high.
- Arbitration (combinational):
  - g0 = r0_valid & (!r1_valid | prio==0); g1 = r1_valid & !g0.
  - rX_ready = gX; rX_ready is never high without rX_valid.
  - At most one grant per cycle.
- Priority update: on any grant, prio <= index of the requester not granted. With no grant, prio holds.
- Issue:
  - On an accept edge A, the granted fields are registered onto mem_* and drive the memory during cycle A..A+1; the memory samples them at edge A+1.
  - In a cycle with no grant, mem_we <= 0 and mem_Mode, addresses and dataIn hold their previous values (idle, no write).
- Tag pipeline:
  - Depth 1+RD_LAT, each stage {valid, id}.
  - Stage 0 is loaded at edge A with {1, granted id}, or {0, x} when idle.
  - The pipeline shifts every edge.
- Response:
  - At edge A+1+RD_LAT, mem_dataOut is captured into rsp_data of the tagged requester, and that requester's rsp_valid is set for exactly one cycle.
  - Accept-to-rsp_valid latency = 2+RD_LAT edges (3 at default).
  - rsp_data holds its value until the next response to the same requester.
- Every command, read or write, produces one response, so the pulse count equals the accept count per requester.
- There is no response backpressure; requesters must always sink responses.
- Throughput: one command per cycle, fully pipelined. Back-to-back accepts produce back-to-back responses in accept order.
- Simultaneous requests: requests alternate strictly (0,1,0,1...) while both valid stay high. A lone requester is granted every cycle.
- busy = OR of all tag-stage valid bits.
- Reset mid-operation: all pending tags are dropped; no rsp_valid appears for commands accepted before reset. Requests presented while rst is high are not accepted (ready = 0 during rst).
- Hazards: a read issued the cycle after a write to the same address returns whatever veda_mem_2 returns; the arbiter does no forwarding.

Test Plan:
- Reset: rst=1 for 2 cycles with both valid high -> no ready, mem_we=0, all rsp_valid=0, busy=0.
- Single requester: r0 writes addr_a=5, data=27 (we=1, mode=0), then reads addr_b=5 -> r0_ready each cycle; mem_we=1 then 0; second r0_rsp_valid arrives 3 edges after its accept with rsp_data=27; r1_rsp_valid never fires.
- Contention: both valid for 4 cycles (r0 writes addr 8 data 26; r1 writes addr 23 data 25) -> grants alternate 0,1,0,1; 4 mem writes; 2 responses to each port, in order.
- Fairness after idle: r1 alone granted once, then both valid -> r0 granted next; with r0 alone granted, then both valid -> r1 granted next.
- Reset mid-flight: accept 2 commands, assert rst one edge later -> zero rsp_valid pulses afterward; busy=0 after reset.
- RD_LAT=3 build: a single read of addr 20 -> rsp_valid 5 edges after accept with the value written earlier; busy high for exactly those cycles.
